// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder with a valid/ready handshake on both sides.
// One operand pair is accepted in IDLE. The block then spends WIDTH cycles in
// RUN, adding one bit pair per cycle LSB-first with a single full adder. It
// then presents sum/cout in DONE until the consumer takes the result.
//
// Optional feature (compile-time macro):
//   SERIAL_ADDER_OVERFLOW_EN : adds the 'overflow' output, which is the
//                              two's-complement overflow flag of the result.
//
// Parameters:
//   WIDTH      operand/result width in bits (2..32)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operand pair (a, b, cin) is presented
//   in_ready   block can accept operands (high only in IDLE, registered)
//   a, b       addends
//   cin        carry-in
//   out_valid  result is valid (high only in DONE, registered)
//   out_ready  consumer accepts the result
//   sum        a + b + cin mod 2^WIDTH
//   cout       carry out of the MSB
//   overflow   two's-complement overflow (only with SERIAL_ADDER_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Full adder built from two half-adder stages plus an OR.
  logic ha1_s, ha1_c, fa_s, ha2_c, fa_c;

  assign ha1_s = a_sr[0] ^ b_sr[0];
  assign ha1_c = a_sr[0] & b_sr[0];
  assign fa_s  = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign fa_c  = ha1_c | ha2_c;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others (e.g. 'carry' below is
  // the carry into the MSB when the overflow flag is formed).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: every datapath register is reset here as well, because the
      // result must read as zero after reset and a partial result must not
      // survive an aborted transaction.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end

        RUN: begin
          // The result fills from the MSB side. After WIDTH shifts, the first
          // sum bit has reached bit 0.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= fa_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow  <= carry ^ fa_c;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder with WIDTH=8. Each vector carries a
// hand-computed expected sum, cout and overflow. The bench also checks
// latency, stalling in DONE, ignored in_valid during RUN, and reset in
// mid-RUN. Overflow checks are active when SERIAL_ADDER_OVERFLOW_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check(tag, 32'(overflow), 32'(exp));
`endif
  endtask

  // Waits a bounded number of cycles for in_ready, sampling 1 time unit
  // after each edge.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Runs one transaction. noisy: keep in_valid high with random operands
  // during RUN. stall: number of cycles out_ready stays low in DONE.
  task automatic run_op(input string tag,
                        input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vcin,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input bit noisy, input int stall);
    wait_ready(tag);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    @(posedge clk); #1;              // edge 0: accept
    in_valid = 1'b0;
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      if (noisy) begin
        in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
        cin = 1'($urandom);
      end
      @(posedge clk); #1;
      check({tag, "_out_valid_early"}, 32'(out_valid), 32'd0);
    end
    if (noisy) begin
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
    end
    @(posedge clk); #1;              // edge WIDTH: result available
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check_ovf({tag, "_overflow"}, exp_ovf);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_stall_cout"}, 32'(cout), 32'(exp_cout));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;              // handshake edge
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_sum_held"}, 32'(sum), 32'(exp_sum));
    check({tag, "_idle_cout_held"}, 32'(cout), 32'(exp_cout));
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check_ovf("rst_overflow", 1'b0);
    #10 rstn = 1'b1;                 // released between edges

    // The first edge after reset release must already accept.
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    run_op("v0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 0);
    run_op("vff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_op("v7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
    run_op("v80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    run_op("vff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
    run_op("stall", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 5);
    run_op("noisy", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 0);

    // Reset in the middle of RUN aborts the transaction.
    wait_ready("abort");
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    #2;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check_ovf("abort_overflow", 1'b0);
    #1 rstn = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("post_abort", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair a, b, cin is presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  addend A.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
REQ-012 cout  output  1  carry-out of the MSB.
REQ-013 overflow  output  1  two's-complement overflow; port exists only under SERIAL_ADDER_OVERFLOW_EN.

Function
REQ-014 FSM states: IDLE, RUN, DONE; single registered state, one-hot or binary.
REQ-015 IDLE: in_ready=1, out_valid=0.
REQ-016 Accept: in_valid&&in_ready at an edge captures a, b into shift registers, carry flop <= cin, bit counter <= 0, state -> RUN.
REQ-017 RUN: in_ready=0, out_valid=0; each cycle adds LSBs of shift registers plus carry flop via one full adder (two half-add stages plus OR).
REQ-018 RUN, per edge: sum bit shifted into result register MSB, result shifted right; operand registers shifted right; carry flop <= full-adder carry; counter +1.
REQ-019 RUN -> DONE on the edge where counter == WIDTH-1; exactly WIDTH RUN cycles.
REQ-020 Latency: accept at edge 0 -> out_valid high immediately after edge WIDTH.
REQ-021 DONE: out_valid=1, in_ready=0; sum, cout (and overflow) held stable until handshake.
REQ-022 out_valid&&out_ready at an edge -> IDLE; next accept no earlier than following edge (throughput one result per WIDTH+2 cycles).
REQ-023 in_valid asserted in RUN or DONE is ignored; no operand capture.
REQ-024 sum/cout reflect last completed result while in IDLE, until next acceptance alters them in RUN.
REQ-025 Arithmetic boundary: a=b=all-ones, cin=1 -> sum all-ones, cout=1; no width extension beyond cout.
REQ-026 No combinational path from in_valid to in_ready or out_ready to out_valid.

Reset
REQ-027 rstn low: state -> IDLE, sum=0, cout=0, overflow=0, counter=0, carry flop=0, operand registers=0, asynchronously.
REQ-028 Reset mid-RUN or in DONE aborts the transaction; partial result discarded, no out_valid pulse.
REQ-029 First acceptance possible on the first clk edge after rstn deasserts.

Configuration
REQ-030 Macro SERIAL_ADDER_OVERFLOW_EN defined: overflow port present; registered at the final RUN edge as carry-into-MSB XOR carry-out-of-MSB; held in DONE.
REQ-031 Macro undefined: overflow port, its register and logic absent; all other behaviour identical.

Verification
REQ-032 WIDTH=8, a=0x0F, b=0x01, cin=0 accepted at edge 0 -> out_valid after edge 8, sum=0x10, cout=0.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with macro overflow=0.
REQ-034 Macro defined: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1; a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
REQ-035 out_ready held low 5 cycles in DONE -> out_valid stays 1, sum/cout unchanged; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 rstn pulsed low at RUN cycle 4 of a=0xAA, b=0x55 -> outputs 0, IDLE, no out_valid; next op a=0x01, b=0x02, cin=1 -> sum=0x04.
REQ-037 in_valid held high with changing a/b during RUN -> result equals sum of values captured at acceptance only.
